col_output_buffer: RTL and testbench
====================================

Name: col_output_buffer

Overview:
- Parametrised, double-buffered result collector for one systolic-array column.
- Captures per-row PE results, any number of rows per cycle, into a write bank.
- Drains each completed bank to the top level over a valid/ready stream, in row order.
- The second bank keeps accepting the next tile while the first bank drains.

Parameters:
ROWS, 8, number of PE rows feeding this column (>=2)
OUTWIDTH, 32, width of one PE result
CNTW, $clog2(ROWS), row index width (derived, not overridden)

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
in_r  input  ROWS*OUTWIDTH  flattened PE results; row r occupies bits [r*OUTWIDTH +: OUTWIDTH]
in_v  input  ROWS  per-row result valid; any subset may be high in one cycle
flush  input  1  commit a partially filled write bank for draining
rev_order  input  1  drain mode: 0 = row 0 first, 1 = row ROWS-1 first; sampled at bank commit
out_data  output  OUTWIDTH  current drained result
out_row  output  CNTW  row index of out_data
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data this cycle
out_last  output  1  out_data is the final entry of the bank
overflow  output  1  sticky: a result was dropped
wr_bank  output  1  index of the bank currently accepting writes

Behaviour:
- Reset: all slot-valid bits clear, both banks free, wr_bank=0, read bank=0, out_valid=0, out_last=0, out_row=0, out_data=0, overflow=0. Reset mid-drain abandons all data immediately.
- Storage: 2 banks x ROWS slots, each slot with a valid bit.
- Write rules:
  - On in_v[r], write in_r row r into slot r of the write bank and set its valid bit.
  - If the slot is already valid, or the write bank is committed: drop the data, keep the stored value, set overflow.
- Bank states: FREE -> FILLING (first write) -> COMMITTED -> DRAINING -> FREE.
- Commit conditions:
  - At the edge where the last empty slot is written, or at a flush edge while at least one slot is valid.
  - flush on an empty bank is ignored.
  - Writes and flush in the same cycle: writes land first, then commit.
  - rev_order is latched per bank at commit.
- Bank swap:
  - After commit, wr_bank toggles on the next edge if the other bank is FREE, or becomes FREE in that same cycle.
  - Otherwise the committed bank holds and all in_v are dropped (overflow) until the swap.
- Drain order and latency:
  - Committed banks drain in commit order.
  - out_valid rises the cycle after commit, provided no drain is active.
  - Visits valid slots only, in ascending order (descending if rev_order was latched 1); empty slots from a flush are skipped.
  - out_data/out_row are registered from the read pointer; out_data=0 whenever out_valid=0.
- Handshake:
  - Transfer occurs when out_valid && out_ready. The pointer advances to the next valid slot on the following cycle.
  - While out_ready=0, out_data, out_row and out_last hold stable.
  - out_last=1 exactly on the final valid slot.
  - The transfer with out_last clears all slot bits, frees the bank and deasserts out_valid next cycle, unless the other bank is already COMMITTED. In that case its first entry is presented with no bubble.
- Counters use full CNTW width; ROWS need not be a power of 2. The pointer never wraps past ROWS-1.
- overflow clears only on reset.

Test Plan:
1. ROWS=8; in_v=8'h01,8'h02..8'h80 over 8 cycles, in_r row r = 100+r; out_ready=1 -> out_valid rises 1 cycle after 8th write; rows 0..7 with data 100..107 on 8 consecutive cycles; out_last with row 7; wr_bank=1.
2. in_v=8'hFF in one cycle, rev_order=1 -> drain order row 7..0, out_last on row 0.
3. Fill bank 0, hold out_ready=0, fill bank 1, then in_v=8'h10 -> overflow=1, stored row 4 of bank 1 unchanged; release out_ready -> 16 back-to-back transfers, no bubble between banks.
4. Write rows 2 and 5 only, pulse flush -> exactly two beats (row 2 then row 5), out_last on row 5; flush with empty bank -> no output.
5. Duplicate in_v[3] before commit -> first value retained, overflow=1.
6. Assert rstn=0 mid-drain for 1 cycle -> next cycle out_valid=0, overflow=0, wr_bank=0; a fresh 8-row fill drains correctly.

Source files
------------

// File: rtl/col_out_if.sv
// col_out_if: valid/ready result stream from a column output buffer to the top level.
//   out_data  - drained PE result (zero while out_valid is low)
//   out_row   - row index of out_data
//   out_valid - out_data is valid
//   out_ready - consumer accepts out_data this cycle
//   out_last  - out_data is the final entry of its bank
//   master: buffer side, slave: consumer side
interface col_out_if #(
    parameter int OUTWIDTH = 32,
    parameter int CNTW     = 3
);
    logic [OUTWIDTH-1:0] out_data;
    logic [CNTW-1:0]     out_row;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    modport master(output out_data, out_row, out_valid, out_last, input out_ready);
    modport slave(input out_data, out_row, out_valid, out_last, output out_ready);
endinterface

// File: rtl/col_output_buffer.sv
// col_output_buffer: double-buffered result collector for one systolic-array column.
//   clk, rstn  - clock, synchronous active-low reset
//   in_r       - flattened PE results, row r at [r*OUTWIDTH +: OUTWIDTH]
//   in_v       - per-row result valid, any subset per cycle
//   flush      - commit a partially filled write bank
//   rev_order  - drain direction latched at commit (1 = highest row first)
//   dout       - result stream (col_out_if master)
//   overflow   - sticky, a result was dropped
//   wr_bank    - bank currently accepting writes
module col_output_buffer #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32,
    localparam int CNTW    = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ROWS*OUTWIDTH-1:0] in_r,
    input  logic [ROWS-1:0]          in_v,
    input  logic                     flush,
    input  logic                     rev_order,
    col_out_if.master                dout,
    output logic                     overflow,
    output logic                     wr_bank
);
    typedef enum logic [1:0] {FREE, FILLING, COMMITTED, DRAINING} bank_t;

    bank_t                    st [2];
    bank_t                    st_n [2];
    logic [1:0][ROWS-1:0]     vld;
    logic [1:0]               rev;
    logic [OUTWIDTH-1:0]      mem [2][ROWS];
    logic                     rd_bank;
    logic                     wr_open, commit, drop, swap;
    logic                     take, fin, adv, start_cur, start_oth, pres, pb, pr, is_last;
    logic [ROWS-1:0]          acc, nv, pm, sel;
    logic [CNTW-1:0]          slot;

    // First set bit of vec in drain direction (lowest index, or highest when dir=1).
    function automatic logic [CNTW-1:0] first_idx(input logic [ROWS-1:0] vec, input logic dir);
        first_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) if (vec[i] && !dir) first_idx = CNTW'(i);
        for (int i = 0; i < ROWS; i++) if (vec[i] && dir) first_idx = CNTW'(i);
    endfunction

    // Bits of vec strictly after pos in drain direction.
    function automatic logic [ROWS-1:0] beyond(input logic [ROWS-1:0] vec, input logic dir,
                                               input logic [CNTW-1:0] pos);
        for (int i = 0; i < ROWS; i++) beyond[i] = vec[i] && (dir ? i < int'(pos) : i > int'(pos));
    endfunction

    always_comb begin
        wr_open   = st[wr_bank] == FREE || st[wr_bank] == FILLING;
        acc       = wr_open ? in_v & ~vld[wr_bank] : '0;
        nv        = vld[wr_bank] | acc;
        drop      = |(in_v & ~acc);
        commit    = wr_open && ((|acc && &nv) || (flush && |nv));
        take      = dout.out_valid && dout.out_ready;
        fin       = take && dout.out_last;
        adv       = take && !dout.out_last;
        start_cur = !dout.out_valid && st[rd_bank] == COMMITTED;
        // A bank already waiting behind the finishing one is presented on the same edge.
        start_oth = fin && st[~rd_bank] == COMMITTED;
        // The other bank counts as free if it releases on this very edge.
        swap      = !wr_open && (st[~wr_bank] == FREE || (fin && rd_bank != wr_bank));
        pres      = start_cur || start_oth || adv;
        pb        = start_oth ? ~rd_bank : rd_bank;
        pr        = rev[pb];
        pm        = adv ? beyond(vld[rd_bank], rev[rd_bank], dout.out_row) : vld[pb];
        slot      = first_idx(pm, pr);
        sel       = ROWS'(1) << slot;
        is_last   = ~|(pm & ~sel);
        st_n      = st;
        if (commit) st_n[wr_bank] = COMMITTED;
        else if (|acc) st_n[wr_bank] = FILLING;
        if (start_cur) st_n[rd_bank] = DRAINING;
        if (fin) st_n[rd_bank] = FREE;
        if (start_oth) st_n[~rd_bank] = DRAINING;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st             <= '{FREE, FREE};
            vld            <= '0;
            rev            <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            overflow       <= 1'b0;
            dout.out_valid <= 1'b0;
            dout.out_data  <= '0;
            dout.out_row   <= '0;
            dout.out_last  <= 1'b0;
        end else begin
            st <= st_n;
            if (wr_open) vld[wr_bank] <= nv;
            if (fin) vld[rd_bank] <= '0;
            for (int r = 0; r < ROWS; r++) if (acc[r]) mem[wr_bank][r] <= in_r[r*OUTWIDTH +: OUTWIDTH];
            if (commit) rev[wr_bank] <= rev_order;
            overflow <= overflow | drop;
            wr_bank  <= wr_bank ^ swap;
            rd_bank  <= rd_bank ^ fin;
            if (pres) begin
                dout.out_valid <= 1'b1;
                dout.out_data  <= mem[pb][slot];
                dout.out_row   <= slot;
                dout.out_last  <= is_last;
            end else if (fin) begin
                dout.out_valid <= 1'b0;
                dout.out_data  <= '0;
                dout.out_row   <= '0;
                dout.out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_col_output_buffer.sv
// tb_col_output_buffer: directed self-checking bench for col_output_buffer (ROWS=8).
module tb_col_output_buffer;
    localparam int ROWS = 8;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [ROWS*W-1:0] in_r = '0;
    logic [ROWS-1:0]   in_v = '0;
    logic              flush = 1'b0;
    logic              rev_order = 1'b0;
    logic              overflow;
    logic              wr_bank;
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;

    typedef struct {int row; int data; int last; int cyc;} beat_t;
    beat_t q[$];

    col_out_if #(.OUTWIDTH(W), .CNTW(3)) ifc();

    col_output_buffer #(.ROWS(ROWS), .OUTWIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .in_r(in_r), .in_v(in_v), .flush(flush),
        .rev_order(rev_order), .dout(ifc), .overflow(overflow), .wr_bank(wr_bank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A beat is recorded when it will transfer on the next rising edge.
    always @(negedge clk)
        if (rstn && ifc.out_valid && ifc.out_ready)
            q.push_back('{int'(ifc.out_row), int'(ifc.out_data), int'(ifc.out_last), cyc});

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(int base, logic [ROWS-1:0] v);
        for (int r = 0; r < ROWS; r++) in_r[r*W +: W] = W'(base + r);
        in_v = v;
        tick;
        in_v = '0;
    endtask

    task automatic wait_beats(string tag, int n);
        for (int i = 0; i < 60 && q.size() < n; i++) tick;
        check({tag, "_beats"}, q.size(), n);
    endtask

    task automatic chk_beat(string tag, int k, int row, int data, int last);
        beat_t b;
        b = '{-1, -1, -1, -1};
        if (k < q.size()) b = q[k];
        check($sformatf("%s_row%0d", tag, k), b.row, row);
        check($sformatf("%s_data%0d", tag, k), b.data, data);
        check($sformatf("%s_last%0d", tag, k), b.last, last);
    endtask

    task automatic chk_gap(string tag, int n);
        int gap;
        gap = (q.size() == n) ? q[n-1].cyc - q[0].cyc : -1;
        check({tag, "_gap"}, gap, n - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        ifc.out_ready = 1'b0;
        tick;
        tick;
        check("rst_valid", ifc.out_valid, 0);
        check("rst_data", ifc.out_data, 0);
        check("rst_row", ifc.out_row, 0);
        check("rst_last", ifc.out_last, 0);
        check("rst_ovf", overflow, 0);
        check("rst_wrbank", wr_bank, 0);
        rstn = 1'b1;
        ifc.out_ready = 1'b1;

        // one row per cycle, ascending drain
        for (int r = 0; r < ROWS; r++) load(100, ROWS'(1 << r));
        check("t1_no_early_valid", ifc.out_valid, 0);
        tick;
        check("t1_valid_rise", ifc.out_valid, 1);
        wait_beats("t1", 8);
        for (int k = 0; k < 8; k++) chk_beat("t1", k, k, 100 + k, int'(k == 7));
        chk_gap("t1", 8);
        tick;
        check("t1_valid_fall", ifc.out_valid, 0);
        check("t1_wrbank", wr_bank, 1);

        // all rows in one cycle, reverse drain
        q.delete();
        rev_order = 1'b1;
        load(200, 8'hFF);
        rev_order = 1'b0;
        wait_beats("t2", 8);
        for (int k = 0; k < 8; k++) chk_beat("t2", k, 7 - k, 207 - k, int'(k == 7));
        tick;
        check("t2_wrbank", wr_bank, 0);

        // both banks full under backpressure, then back-to-back drain
        q.delete();
        ifc.out_ready = 1'b0;
        load(300, 8'hFF);
        tick;
        load(400, 8'hFF);
        tick;
        check("t3_ovf_pre", overflow, 0);
        load(900, 8'h10);
        check("t3_ovf", overflow, 1);
        check("t3_wrbank", wr_bank, 1);
        check("t3_hold_valid", ifc.out_valid, 1);
        tick;
        tick;
        check("t3_hold_data", ifc.out_data, 300);
        check("t3_hold_row", ifc.out_row, 0);
        check("t3_hold_last", ifc.out_last, 0);
        ifc.out_ready = 1'b1;
        wait_beats("t3", 16);
        for (int k = 0; k < 16; k++)
            chk_beat("t3", k, k % 8, (k < 8 ? 300 : 400) + k % 8, int'(k % 8 == 7));
        chk_gap("t3", 16);

        // partial bank committed by flush, then flush on an empty bank
        q.delete();
        load(500, 8'h24);
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        wait_beats("t4", 2);
        chk_beat("t4", 0, 2, 502, 0);
        chk_beat("t4", 1, 5, 505, 1);
        repeat (4) tick;
        check("t4_only_two", q.size(), 2);
        check("t4_idle", ifc.out_valid, 0);
        check("t4_wrbank", wr_bank, 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        repeat (4) tick;
        check("t4_empty_flush_beats", q.size(), 2);
        check("t4_empty_flush_valid", ifc.out_valid, 0);
        check("t4_empty_flush_wrbank", wr_bank, 1);

        // reset in the middle of a drain
        load(600, 8'hFF);
        tick;
        tick;
        check("t6_pre_valid", ifc.out_valid, 1);
        check("t6_pre_ovf", overflow, 1);
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        check("t6_valid", ifc.out_valid, 0);
        check("t6_ovf", overflow, 0);
        check("t6_wrbank", wr_bank, 0);
        check("t6_data", ifc.out_data, 0);
        q.delete();
        load(700, 8'hFF);
        wait_beats("t6", 8);
        for (int k = 0; k < 8; k++) chk_beat("t6", k, k, 700 + k, int'(k == 7));
        chk_gap("t6", 8);

        // duplicate write keeps the first value
        q.delete();
        load(800, 8'h08);
        check("t5_ovf_pre", overflow, 0);
        load(850, 8'h08);
        check("t5_ovf", overflow, 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        wait_beats("t5", 1);
        chk_beat("t5", 0, 3, 803, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
